// File: rtl/audio_pkg.sv
// Shared types and default sizing for the spectral path
// (frame scheduler, window and FFT).
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } sched_state_t;

    localparam int AUDIO_SAMPLE_WIDTH = 16;
    localparam int AUDIO_FRAME_LEN    = 256;
    localparam int AUDIO_HOP          = 128;

endpackage

// File: rtl/frame_ring_buffer.sv
// Simple dual-port sample RAM: one write port and one registered read port
// with read enable, so the read data holds while the consumer stalls.
module frame_ring_buffer #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     we_in,
    input  logic [$clog2(DEPTH)-1:0] waddr_in,
    input  logic [WIDTH-1:0]         wdata_in,
    input  logic                     re_in,
    input  logic [$clog2(DEPTH)-1:0] raddr_in,
    output logic [WIDTH-1:0]         rdata_out
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_in) begin
        if (we_in) begin
            mem[waddr_in] <= wdata_in;
        end
    end

    // Same-cycle write and read of one address returns the old word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rdata_q <= '0;
        end else if (re_in) begin
            rdata_q <= mem[raddr_in];
        end
    end

    assign rdata_out = rdata_q;

endmodule

// File: rtl/fft_frame_scheduler.sv
// Buffers decimated samples in a ring and, every HOP new samples, streams one
// overlapping FRAME_LEN-sample frame (oldest first) to the window/FFT stage.
module fft_frame_scheduler
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int FRAME_LEN    = AUDIO_FRAME_LEN,
    parameter int HOP          = AUDIO_HOP
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           enable_in,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid_in,
    output logic signed [SAMPLE_WIDTH-1:0] frame_out_data,
    output logic [$clog2(FRAME_LEN)-1:0]   frame_out_index,
    output logic                           frame_out_valid,
    input  logic                           frame_out_ready,
    output logic                           frame_out_last,
    output logic                           frame_start_out,
    output logic                           busy_out,
    output logic                           overrun_out,
    output logic [15:0]                    frames_done_out,
    output sched_state_t                   state_out
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(2 * HOP) + 1;
    localparam logic [CW-1:0] FULL    = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LAST_RD = CW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] HOP_V   = HW'(HOP);
    localparam logic [HW-1:0] HOP_MAX = HW'(2 * HOP);

    sched_state_t  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, base_q, base_d, index_q, index_d;
    logic [CW-1:0] fill_q, fill_d, rd_idx_q, rd_idx_d;
    logic [CW-1:0] hs_cnt_q, hs_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [HW-1:0] hop_q, hop_d;
    logic          valid_q, valid_d, last_q, last_d, start_q, start_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   done_q, done_d;

    logic                    we, trigger, hs, hs_last, rd_en, capture, hop_inc;
    logic [AW-1:0]           rd_addr;
    logic [CW:0]             wr_next, hs_now;
    logic [SAMPLE_WIDTH-1:0] rd_data;

    // Stream handshake: a beat transfers on a cycle where frame_out_valid and
    // frame_out_ready are both high; while valid is high without ready, data,
    // index and last hold, and valid only falls after a transfer.
    assign we      = sample_valid_in && (state_q != IDLE);
    assign trigger = (fill_q == FULL) && (hop_q >= HOP_V);
    assign hs      = valid_q && frame_out_ready;
    assign hs_last = hs && last_q;
    assign rd_en   = (state_q == STREAM) && (rd_idx_q != FULL) && (!valid_q || frame_out_ready);
    assign rd_addr = base_q + rd_idx_q[AW-1:0];
    // Samples arriving before the ring is full belong to the first frame, so
    // they may only bank a single hop.
    assign hop_inc = we && ((fill_q == FULL) || (hop_q < HOP_V));
    assign wr_next = {1'b0, wr_cnt_q} + (CW+1)'(1);
    assign hs_now  = {1'b0, hs_cnt_q} + {{CW{1'b0}}, hs};

    frame_ring_buffer #(
        .DEPTH (FRAME_LEN),
        .WIDTH (SAMPLE_WIDTH)
    ) u_ring (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .we_in     (we),
        .waddr_in  (wr_ptr_q),
        .wdata_in  (sample_in),
        .re_in     (rd_en),
        .raddr_in  (rd_addr),
        .rdata_out (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        base_d    = base_q;
        index_d   = index_q;
        fill_d    = fill_q;
        rd_idx_d  = rd_idx_q;
        hs_cnt_d  = hs_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        hop_d     = hop_q;
        valid_d   = valid_q;
        last_d    = last_q;
        start_d   = 1'b0;
        overrun_d = overrun_q;
        done_d    = done_q;
        capture   = 1'b0;

        if (rd_en) begin
            valid_d  = 1'b1;
            index_d  = rd_idx_q[AW-1:0];
            last_d   = (rd_idx_q == LAST_RD);
            rd_idx_d = rd_idx_q + CW'(1);
        end else if (hs) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (hs) begin
            hs_cnt_d = hs_cnt_q + CW'(1);
        end
        if (hs_last) begin
            done_d = done_q + 16'd1;
        end

        if (we) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (we && (fill_q != FULL)) begin
            fill_d = fill_q + CW'(1);
        end
        if (we && (state_q == STREAM)) begin
            if (wr_cnt_q != FULL) begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
            if (wr_next > hs_now) begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (enable_in) state_d = FILL;
            end
            FILL: begin
                if (!enable_in)   state_d = IDLE;
                else if (trigger) capture = 1'b1;
            end
            STREAM: begin
                if (hs_last) begin
                    if (!enable_in)   state_d = DRAIN;
                    else if (trigger) capture = 1'b1;
                    else              state_d = FILL;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d  = STREAM;
            base_d   = wr_ptr_q;
            start_d  = 1'b1;
            rd_idx_d = '0;
            hs_cnt_d = '0;
            wr_cnt_d = we ? CW'(1) : '0;
            // A write on the trigger cycle lands on the new frame's oldest slot
            // before it has been read.
            if (we) overrun_d = 1'b1;
            hop_d = hop_q - HOP_V + HW'(hop_inc);
        end else if (hop_inc) begin
            if (hop_q == HOP_MAX) overrun_d = 1'b1;
            else                  hop_d = hop_q + HW'(1);
        end

        if ((state_d == IDLE) || (state_d == DRAIN)) begin
            fill_d = '0;
            hop_d  = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            base_q    <= '0;
            index_q   <= '0;
            fill_q    <= '0;
            rd_idx_q  <= '0;
            hs_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            hop_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            base_q    <= base_d;
            index_q   <= index_d;
            fill_q    <= fill_d;
            rd_idx_q  <= rd_idx_d;
            hs_cnt_q  <= hs_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            hop_q     <= hop_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            start_q   <= start_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    assign frame_out_data  = rd_data;
    assign frame_out_index = index_q;
    assign frame_out_valid = valid_q;
    assign frame_out_last  = last_q;
    assign frame_start_out = start_q;
    assign busy_out        = (state_q == STREAM);
    assign overrun_out     = overrun_q;
    assign frames_done_out = done_q;
    assign state_out       = state_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with FRAME_LEN=8, HOP=4.
module tb_fft_frame_scheduler;
    import audio_pkg::*;

    localparam int SW = 16;
    localparam int FL = 8;
    localparam int HP = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic signed [SW-1:0] sample_in;
    logic                 sample_valid;
    logic signed [SW-1:0] data;
    logic [2:0]           index;
    logic                 valid;
    logic                 ready;
    logic                 last;
    logic                 start;
    logic                 busy;
    logic                 overrun;
    logic [15:0]          done;
    sched_state_t         state;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int first_feed;
        int n_feed;
        int ready_mode;
        int exp_first;
        int exp_done;
    } frame_vec_t;

    frame_vec_t vecs[4];

    fft_frame_scheduler #(
        .SAMPLE_WIDTH (SW),
        .FRAME_LEN    (FL),
        .HOP          (HP)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .enable_in       (enable),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid),
        .frame_out_data  (data),
        .frame_out_index (index),
        .frame_out_valid (valid),
        .frame_out_ready (ready),
        .frame_out_last  (last),
        .frame_start_out (start),
        .busy_out        (busy),
        .overrun_out     (overrun),
        .frames_done_out (done),
        .state_out       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] sv(input int k);
        return 16'(k * 257) ^ 16'h8000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic feed(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sample_in    = sv(first + k);
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic quiet(input int n, input string name);
        int seen = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (start || valid) seen++;
        end
        check(name, seen, 0);
    endtask

    // exp_first < 0 skips data checks; ready_mode 1 toggles ready 1-0-0-1 per 4 cycles.
    task automatic collect(input int exp_first, input int ready_mode, input int dis_idx,
                           input int exp_starts);
        int hs_cnt = 0;
        int starts = 0;
        int cyc = 0;
        int start_cyc = -1;
        int first_valid = -1;
        bit fin = 1'b0;
        bit stalled = 1'b0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            if (ready_mode == 1) ready = (((cyc / 4) % 4) == 0) || (((cyc / 4) % 4) == 3);
            else                 ready = 1'b1;
            if (start) begin
                starts++;
                start_cyc = cyc;
            end
            if (stalled) check("valid_held", valid, 1);
            if (valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (exp_first >= 0) check("data", $unsigned(data), sv(exp_first + hs_cnt));
                check("index", index, hs_cnt);
                check("last", last, (hs_cnt == FL - 1));
                if (ready) begin
                    if (hs_cnt == dis_idx) enable = 1'b0;
                    if (last) fin = 1'b1;
                    hs_cnt++;
                end
            end
            stalled = valid && !ready;
            cyc++;
        end
        check("frame_complete", fin, 1);
        check("beats", hs_cnt, FL);
        check("starts", starts, exp_starts);
        if (exp_starts == 1) check("start_to_valid", first_valid - start_cyc, 1);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1,  8, 0, 1,  1};
        vecs[1] = '{9,  4, 0, 5,  2};
        vecs[2] = '{13, 4, 1, 9,  3};
        vecs[3] = '{17, 4, 0, 13, 4};

        rst          = 1'b1;
        enable       = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        ready        = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_done", done, 0);
        check("rst_data", $unsigned(data), 0);
        check("rst_state", state, IDLE);

        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check("enter_fill", state, FILL);

        for (int i = 0; i < 4; i++) begin
            feed(vecs[i].first_feed, vecs[i].n_feed);
            collect(vecs[i].exp_first, vecs[i].ready_mode, -1, 1);
            check("busy_after", busy, 0);
            check("done_count", done, vecs[i].exp_done);
            check("no_overrun", overrun, 0);
            check("state_after", state, FILL);
        end

        // Disable at index 3: frame finishes, DRAIN, IDLE, then full refill.
        feed(21, 4);
        collect(17, 0, 3, 1);
        check("dis_busy", busy, 0);
        check("dis_drain", state, DRAIN);
        check("dis_done", done, 5);
        @(negedge clk);
        check("dis_idle", state, IDLE);
        feed(100, 4);
        quiet(6, "dis_ignored");
        check("dis_done_hold", done, 5);
        enable = 1'b1;
        feed(25, 4);
        quiet(20, "refill_no_frame");
        feed(29, 4);
        collect(25, 0, -1, 1);
        check("refill_done", done, 6);
        check("refill_overrun", overrun, 0);

        // Reset while index 5 is presented.
        feed(33, 4);
        begin
            int t = 0;
            while (!(valid && index == 3'd5) && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        check("reach_idx5", (valid && index == 3'd5), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_valid", valid, 0);
        check("mrst_last", last, 0);
        check("mrst_done", done, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_state", state, IDLE);
        check("mrst_busy", busy, 0);
        rst = 1'b0;

        // Overrun: stalled frame while samples keep arriving.
        ready = 1'b0;
        @(negedge clk);
        feed(40, 8);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sample_valid = (c % 2 == 0);
            sample_in    = sv(50 + c);
        end
        sample_valid = 1'b0;
        check("ovr_set", overrun, 1);
        check("ovr_busy", busy, 1);
        check("ovr_stall_valid", valid, 1);
        check("ovr_stall_index", index, 0);
        collect(-1, 0, -1, 0);
        check("ovr_sticky", overrun, 1);
        check("ovr_done", done, 1);
        check("ovr_retrigger_start", start, 1);
        check("ovr_retrigger_busy", busy, 1);
        collect(-1, 0, -1, 0);
        check("ovr_done2", done, 2);
        check("ovr_sticky2", overrun, 1);

        rst = 1'b1;
        @(negedge clk);
        check("final_overrun_clear", overrun, 0);
        check("final_done_clear", done, 0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
